// File: rtl/uart_prog_tx.sv
// Programmable-baud 8N1 UART transmitter fed by a small byte FIFO.
// Define UART_PROG_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_prog_tx #(
  parameter int FIFO_DEPTH = 4,
  parameter int BAUD_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BAUD_W-1:0] baud_cnt,
  input  logic              trmt,
  input  logic [7:0]        tx_data,
  output logic              TX,
  output logic              tx_done,
  output logic              busy,
  output logic              full,
  output logic              empty,
  output logic              ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);

`ifdef UART_PROG_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  // FIFO storage and bookkeeping
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full_q, empty_q, ovf_q;
  logic          push, pop;
  logic [7:0]    head;

  // Transmit FSM
  state_t            state_q;
  logic [BAUD_W-1:0] baud_q, bcnt_q, b_eff;
  logic [7:0]        shreg_q;
  logic [2:0]        bit_q;
  logic              tx_q, done_q, busy_q, bit_end;
`ifdef UART_PROG_TX_PARITY_EN
  logic              par_q;
`endif

  assign head    = mem_q[rd_q];
  assign bit_end = (bcnt_q == '0);
  assign b_eff   = (baud_cnt < BAUD_W'(2)) ? BAUD_W'(2) : baud_cnt;

  // Pop from IDLE, or on the last stop-bit cycle so the next start bit follows with no gap.
  assign pop  = !empty_q && ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_end));
  assign push = trmt && !full_q;

  assign cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == (AW+1)'(FIFO_DEPTH));
      empty_q <= (cnt_d == '0);
      if (trmt && full_q) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bcnt_q  <= '0;
      shreg_q <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef UART_PROG_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      // Pulse lands on the final clock of the stop bit (B >= 2 guarantees bcnt passes 1).
      done_q <= (state_q == S_STOP) && (bcnt_q == BAUD_W'(1));
      if (pop) begin
        state_q <= S_START;
        shreg_q <= head;
        baud_q  <= b_eff;
        bcnt_q  <= b_eff - BAUD_W'(1);
        bit_q   <= '0;
        tx_q    <= 1'b0;
        busy_q  <= 1'b1;
`ifdef UART_PROG_TX_PARITY_EN
        par_q   <= ^head;
`endif
      end else if (state_q != S_IDLE) begin
        bcnt_q <= bit_end ? baud_q - BAUD_W'(1) : bcnt_q - BAUD_W'(1);
        if (bit_end) begin
          case (state_q)
            S_START: begin
              state_q <= S_DATA;
              tx_q    <= shreg_q[0];
            end
            S_DATA: begin
              if (bit_q == 3'd7) begin
`ifdef UART_PROG_TX_PARITY_EN
                state_q <= S_PAR;
                tx_q    <= par_q;
`else
                state_q <= S_STOP;
                tx_q    <= 1'b1;
`endif
              end else begin
                shreg_q <= {1'b0, shreg_q[7:1]};
                tx_q    <= shreg_q[1];
                bit_q   <= bit_q + 3'd1;
              end
            end
`ifdef UART_PROG_TX_PARITY_EN
            S_PAR: begin
              state_q <= S_STOP;
              tx_q    <= 1'b1;
            end
`endif
            S_STOP: begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
            default: begin
              state_q <= S_IDLE;
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign TX      = tx_q;
  assign tx_done = done_q;
  assign busy    = busy_q;
  assign full    = full_q;
  assign empty   = empty_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_uart_prog_tx.sv
// Randomized bench for uart_prog_tx against a frame-level timing model of the serial line and FIFO.
module tb_uart_prog_tx;
  localparam int DEPTH = 4;
  localparam int BW    = 16;
`ifdef UART_PROG_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic          clk = 1'b0;
  logic          rst, trmt;
  logic [BW-1:0] baud_cnt;
  logic [7:0]    tx_data;
  logic          TX, tx_done, busy, full, empty, ovf;

  uart_prog_tx #(.FIFO_DEPTH(DEPTH), .BAUD_W(BW)) dut (
    .clk(clk), .rst(rst), .baud_cnt(baud_cnt), .trmt(trmt), .tx_data(tx_data),
    .TX(TX), .tx_done(tx_done), .busy(busy), .full(full), .empty(empty), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0, cyc = 0;

  // Model: queue of accepted bytes plus the active frame's start edge, bit length and end edge.
  logic [7:0] mq[$];
  logic [7:0] cur;
  bit         in_frame = 0, m_ovf = 0;
  int         fstart = 0, fend = 0, bq = 2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit pre_full;
    if (rst) begin
      mq.delete();
      in_frame = 0;
      m_ovf    = 0;
      return;
    end
    pre_full = (mq.size() == DEPTH);
    if (in_frame && cyc == fend) in_frame = 0;
    if (!in_frame && mq.size() != 0) begin
      cur      = mq.pop_front();
      fstart   = cyc;
      bq       = (int'(baud_cnt) < 2) ? 2 : int'(baud_cnt);
      fend     = cyc + FB * bq;
      in_frame = 1;
    end
    if (trmt) begin
      if (pre_full) m_ovf = 1;
      else          mq.push_back(tx_data);
    end
  endtask

  function automatic logic exp_tx();
    int k;
    if (!in_frame) return 1'b1;
    k = (cyc - fstart) / bq;
    if (k == 0) return 1'b0;
    if (k <= 8) return cur[k-1];
    if (FB == 11 && k == 9) return ^cur;
    return 1'b1;
  endfunction

  task automatic step(input logic r, input logic t, input logic [7:0] d, input logic [BW-1:0] b);
    rst = r; trmt = t; tx_data = d; baud_cnt = b;
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    chk("TX",      TX,      exp_tx());
    chk("tx_done", tx_done, in_frame && (cyc == fend - 1));
    chk("busy",    busy,    in_frame);
    chk("full",    full,    mq.size() == DEPTH);
    chk("empty",   empty,   mq.size() == 0);
    chk("ovf",     ovf,     m_ovf);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic [BW-1:0] b);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, b);
  endtask

  logic [7:0] burst [6] = '{8'hA5, 8'h3C, 8'h00, 8'hFF, 8'h81, 8'h7E};

  initial begin
    rst = 1'b1; trmt = 1'b0; tx_data = '0; baud_cnt = 16'd108;
    step(1'b1, 1'b0, 8'h00, 16'd108);
    step(1'b1, 1'b0, 8'h00, 16'd108);
    // single byte at 108 clocks per bit
    step(1'b0, 1'b1, 8'h55, 16'd108);
    idle(1100, 16'd108);
    // back-to-back burst overflowing the FIFO
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, burst[i], 16'd6);
    idle(5 * FB * 6 + 20, 16'd6);
    // baud change mid-frame only affects the next frame
    step(1'b0, 1'b1, 8'h0F, 16'd108);
    idle(300, 16'd108);
    step(1'b0, 1'b1, 8'hF0, 16'd54);
    idle(FB * 108 + FB * 54, 16'd54);
    // reset mid-frame with bytes queued
    step(1'b0, 1'b1, 8'hAA, 16'd108);
    step(1'b0, 1'b1, 8'h11, 16'd108);
    step(1'b0, 1'b1, 8'h22, 16'd108);
    idle(500, 16'd108);
    step(1'b1, 1'b0, 8'h00, 16'd108);
    idle(200, 16'd108);
    // random traffic, small baud values including the clamped 0 and 1
    for (int s = 0; s < 40; s++) begin
      int rate;
      rate = $urandom_range(1, 40);
      for (int i = 0; i < 400; i++)
        step($urandom_range(0, 1499) == 0, $urandom_range(0, rate) == 0,
             8'($urandom), BW'($urandom_range(0, 7)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
